ps2_frame_receiver: RTL
=======================

PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive stable Clock cycles required before the filtered PS/2 clock changes.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 25000: Clock cycles without a sample strobe before an open frame is aborted (1 ms at 25 MHz).
REQ-003 SHALL have port Clock  input  1  system clock (25 MHz); the block has one clock.
REQ-004 SHALL have port Reset  input  1  reset, synchronous to Clock and active-high.
REQ-005 SHALL have port iPS2_CLK  input  1  raw asynchronous PS/2 clock.
REQ-006 SHALL have port iPS2_DATA  input  1  raw asynchronous PS/2 data.
REQ-007 SHALL have port oScanCode  output  8  last good scan code (make code or post-prefix code).
REQ-008 SHALL have port oValid  output  1  one-cycle pulse; oScanCode/oBreak/oExtended are valid in that cycle.
REQ-009 SHALL have port oBreak  output  1  the code was preceded by 0xF0.
REQ-010 SHALL have port oExtended  output  1  the code was preceded by 0xE0.
REQ-011 SHALL have port oParityError  output  1  one-cycle pulse on an odd-parity failure.
REQ-012 SHALL have port oFrameError  output  1  one-cycle pulse on a bad stop bit or a timeout.
REQ-013 SHALL have port oBusy  output  1  high while the FSM is not in IDLE.

Function
REQ-014 SHALL synchronize iPS2_CLK and iPS2_DATA through two flops each before any other use.
REQ-015 Filtered clock SHALL take a new value only after the synchronized clock has held that value for FILTER_LEN consecutive cycles; shorter pulses SHALL be ignored.
REQ-016 A 1-to-0 transition of the filtered clock SHALL generate a one-cycle sample strobe; the synchronized data is sampled in that cycle.
REQ-017 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-018 IDLE: a strobe with data=0 SHALL go to DATA with bit count 0; a strobe with data=1 SHALL stay in IDLE (spurious, no error).
REQ-019 DATA: SHALL shift 8 bits LSB-first, one per strobe; the 8th strobe SHALL go to PARITY.
REQ-020 PARITY: SHALL capture the parity bit on a strobe and go to STOP.
REQ-021 STOP: on a strobe the FSM SHALL return to IDLE and check the frame as below.
REQ-021a Stop=1 with odd parity over data+parity: frame is good.
REQ-021b Stop=0: oFrameError pulse.
REQ-021c Stop=1 with even parity: oParityError pulse.
REQ-021d If both errors are present, only oFrameError SHALL pulse.
REQ-022 A good 0xF0 SHALL set the internal break flag and a good 0xE0 the internal extended flag; neither SHALL pulse oValid.
REQ-023 Any other good code SHALL pulse oValid one cycle after the STOP strobe, load oScanCode, drive oBreak/oExtended from the flags, then clear both flags in the same cycle.
REQ-024 oScanCode, oBreak and oExtended SHALL hold their values until the next oValid.
REQ-025 Any error SHALL clear both flags and SHALL leave oScanCode unchanged.
REQ-026 In DATA, PARITY or STOP, TIMEOUT_CYCLES cycles without a strobe SHALL force IDLE with an oFrameError pulse; the counter restarts on every strobe.
REQ-027 oValid, oParityError and oFrameError SHALL never be high in the same cycle.

Reset
REQ-028 Reset SHALL force IDLE and clear the bit count, shift register, timeout counter and both flags.
REQ-029 Reset SHALL set the filtered clock and the synchronizer flops to 1.
REQ-030 Reset SHALL drive all outputs to 0.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame with no error pulse; reception SHALL resume on the next start bit after release.

Verification
REQ-032 Frame 0x1C (parity 0, stop 1), 10 µs half-period -> one oValid, oScanCode=0x1C, oBreak=0, oExtended=0.
REQ-033 Frames F0 (parity 1) then 1C -> exactly one oValid, oScanCode=0x1C, oBreak=1; a following 1C -> oBreak=0.
REQ-034 Frames E0 then 75 (parity 0) -> oValid with oScanCode=0x75, oExtended=1, oBreak=0.
REQ-035 0x1C with parity 1 -> oParityError pulse, no oValid, oScanCode keeps its prior value; 0x1C with stop 0 -> oFrameError only.
REQ-036 Glitch: 3-cycle low pulse on iPS2_CLK inside IDLE and inside DATA -> no strobe, bit count unchanged, a following good frame decodes correctly.
REQ-037 Abort: stop after 5 data bits, idle for 25000 cycles -> oFrameError pulse, oBusy=0; Reset after 3 bits -> oBusy=0, no pulses, next frame 0x1C is decoded.

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and de-glitches the PS/2 clock,
// decodes 11-bit frames and folds 0xF0/0xE0 prefixes into break/extended flags.
module ps2_frame_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 25000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    output logic [7:0] oScanCode,
    output logic       oValid,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oParityError,
    output logic       oFrameError,
    output logic       oBusy
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state, state_next;
    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          strobe;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;
    logic          brk_flag, ext_flag;
    logic          frame_end, timeout;
    logic          good, par_bad, stop_bad;

    // Filtered clock only follows the synchronized clock after FILTER_LEN
    // consecutive disagreeing cycles; the strobe marks its falling edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            strobe   <= 1'b0;
        end else begin
            clk_s1 <= iPS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= iPS2_DATA;
            dat_s2 <= dat_s1;
            strobe <= 1'b0;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
                strobe   <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_end  = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE:    if (strobe && !dat_s2) state_next = DATA;
            DATA:    if (strobe && bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  if (strobe) state_next = STOP;
            STOP: begin
                if (strobe) begin
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE && !strobe && to_cnt == TO_LAST) begin
            state_next = IDLE;
            timeout    = 1'b1;
        end
    end

    // A bad stop bit masks any parity failure in the same frame.
    assign stop_bad = frame_end & ~dat_s2;
    assign par_bad  = frame_end & dat_s2 & ~(^{shift, parity_bit});
    assign good     = frame_end & dat_s2 & (^{shift, parity_bit});
    assign oBusy    = (state != IDLE);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bit_cnt      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
            to_cnt       <= '0;
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
            oScanCode    <= '0;
            oValid       <= 1'b0;
            oBreak       <= 1'b0;
            oExtended    <= 1'b0;
            oParityError <= 1'b0;
            oFrameError  <= 1'b0;
        end else begin
            oValid       <= 1'b0;
            oParityError <= par_bad;
            oFrameError  <= stop_bad | timeout;

            if (state == IDLE || strobe) to_cnt <= '0;
            else                         to_cnt <= to_cnt + 1'b1;

            if (strobe) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift   <= {dat_s2, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: parity_bit <= dat_s2;
                    default: ;
                endcase
            end

            if (stop_bad || par_bad || timeout) begin
                brk_flag <= 1'b0;
                ext_flag <= 1'b0;
            end else if (good) begin
                if (shift == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (shift == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else begin
                    oValid    <= 1'b1;
                    oScanCode <= shift;
                    oBreak    <= brk_flag;
                    oExtended <= ext_flag;
                    brk_flag  <= 1'b0;
                    ext_flag  <= 1'b0;
                end
            end
        end
    end

endmodule
